cpu_ctrl_fsm: RTL and testbench
===============================

Name: cpu_ctrl_fsm

Overview:
Multi-cycle control sequencer for the 19-bit CPU. It steps each instruction through FETCH, DECODE, EXECUTE, MEM and WRITEBACK, driving the enables and selects for the PC, IR, register file, ALU and data memory. It consumes the type flags and opcode produced by the instruction decoder. It handles request/ready handshakes to the instruction and data memories.

Parameters:
- RESET_PC, 19'h0, PC value loaded on reset; passed to the PC mux through `pc_sel_o=2'd3`.
- MEM_TIMEOUT, 16, maximum cycles to wait for any ready; on expiry the FSM enters FAULT.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- imem_req_o  out  1  instruction fetch request
- imem_ready_i  in  1  instruction memory data valid this cycle
- ir_we_o  out  1  latch fetched word into IR
- op_i  in  4  opcode from decoder
- r_type_i, i_type_i, s_type_i, b_type_i, u_type_i, j_type_i, c_type_i  in  1 each  decoder type flags
- branch_taken_i  in  1  ALU compare result
- alu_src_b_o  out  1  0 = rs2, 1 = immediate
- alu_src_a_o  out  1  0 = rs1, 1 = PC
- dmem_req_o  out  1  data memory request
- dmem_we_o  out  1  data memory write (valid with dmem_req_o)
- dmem_ready_i  in  1  data memory done
- rf_we_o  out  1  register file write enable (one cycle)
- wb_sel_o  out  2  0 = ALU, 1 = memory data, 2 = PC+1, 3 = immediate
- pc_we_o  out  1  PC update enable (one cycle)
- pc_sel_o  out  2  0 = PC+1, 1 = PC+imm, 2 = ALU result, 3 = RESET_PC
- halted_o  out  1  core halted (sticky)
- fault_o  out  1  illegal instruction or timeout (sticky)
- state_o  out  3  current state, for debug

Behaviour:
- State encoding: RESET=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, FAULT=7.
- Reset state:
  - When `rst` is high at a clock edge, the FSM goes to RESET.
  - All outputs are 0, except `pc_sel_o=3` and `pc_we_o=1` while in RESET.
  - The timeout counter clears.
  - Reset mid-transaction drops any outstanding request in the next cycle.
- RESET -> FETCH unconditionally after one cycle.
- FETCH:
  - `imem_req_o=1` is held until `imem_ready_i`.
  - On ready: `ir_we_o=1` for that cycle, then go to DECODE.
- DECODE: one cycle, no enables; the decoder flags are sampled here. Next state:
  - `c_type_i` -> HALT.
  - No flag set, or more than one flag set -> FAULT.
  - Otherwise -> EXEC.
- EXEC, by instruction class:
  - r_type: `alu_src_a=0`, `alu_src_b=0`, then WB with `wb_sel=0`.
  - i_type, `op_i==I_TYPE_0` (load): `alu_src_b=1`, then MEM.
  - i_type, `op_i==I_TYPE_1` (ALU immediate): `alu_src_b=1`, then WB with `wb_sel=0`.
  - i_type, `op_i==I_TYPE_2` (jump-register): `alu_src_b=1`, then WB with `wb_sel=2` and `pc_sel=2`.
  - s_type: `alu_src_b=1`, then MEM.
  - b_type: `pc_we_o=1` this cycle. `pc_sel=1` if `branch_taken_i`, else 0. Then FETCH; no register write.
  - u_type: WB with `wb_sel=3`.
  - j_type: WB with `wb_sel=2` and `pc_sel=1`.
- MEM:
  - `dmem_req_o=1` is held until `dmem_ready_i`.
  - `dmem_we_o=1` for stores only.
  - On ready: loads go to WB with `wb_sel=1`; stores go to FETCH with `pc_we=1`, `pc_sel=0` in the ready cycle.
- WB: exactly one cycle.
  - `rf_we_o=1` and `pc_we_o=1`, with `pc_sel` as selected in EXEC (default 0).
  - Then FETCH.
- `wb_sel_o` and `pc_sel_o` are registered at the EXEC exit and stay stable through MEM and WB.
- Latency (excluding wait states):
  - branch: 3 cycles
  - R, I-ALU, U, J, jump-register: 4 cycles
  - store: 4 cycles
  - load: 5 cycles
  - Each cycle of not-ready adds one cycle.
- Timeout:
  - The counter increments each cycle a request is not acknowledged, and clears on ready.
  - Reaching MEM_TIMEOUT goes to FAULT and drops the request.
- Ready while not requesting is ignored.
- HALT and FAULT are terminal until `rst`. All enables are 0; `halted_o` or `fault_o` is 1 respectively.
- `rf_we_o`, `pc_we_o`, `ir_we_o` and `dmem_req_o` are never asserted in the same cycle as `rst`.

Test Plan:
- R-type add, `imem_ready_i` immediate:
  - FETCH -> DECODE -> EXEC -> WB.
  - `rf_we_o=1` and `pc_we_o` with `pc_sel=0` both occur on cycle 4.
  - FETCH again on cycle 5.
- Load with `dmem_ready_i` delayed 3 cycles:
  - `dmem_req_o` is high for 4 cycles with `dmem_we_o=0`.
  - Then WB with `wb_sel=1`; total latency 8 cycles.
- Branch:
  - `branch_taken_i=1` -> `pc_we_o=1` with `pc_sel=1` in EXEC, no `rf_we_o`.
  - `branch_taken_i=0` -> `pc_sel=0`.
- C-type opcode -> HALT. `halted_o=1` stays set for 20 cycles; no further `imem_req_o`.
- Decoder flags all 0 -> FAULT (`fault_o=1`).
  - Separately, `imem_ready_i` held low 16 cycles -> FAULT, and `imem_req_o` drops.
- `rst` asserted during MEM with `dmem_req_o` high:
  - Next cycle: `state_o=0`, `dmem_req_o=0`, `pc_sel=3`.
  - Then FETCH.

Source files
------------

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control sequencer for the 19-bit CPU.
// Steps each instruction through FETCH, DECODE, EXEC, MEM and WB. Drives the
// PC, IR, register file, ALU and data-memory controls, and times out stalled
// memory handshakes into FAULT.
module cpu_ctrl_fsm #(
  parameter logic [18:0] RESET_PC    = 19'h0,
  parameter int          MEM_TIMEOUT = 16,
  parameter logic [3:0]  I_TYPE_0    = 4'h0,
  parameter logic [3:0]  I_TYPE_1    = 4'h1,
  parameter logic [3:0]  I_TYPE_2    = 4'h2
) (
  input  logic       clk,
  input  logic       rst,
  output logic       imem_req_o,
  input  logic       imem_ready_i,
  output logic       ir_we_o,
  input  logic [3:0] op_i,
  input  logic       r_type_i,
  input  logic       i_type_i,
  input  logic       s_type_i,
  input  logic       b_type_i,
  input  logic       u_type_i,
  input  logic       j_type_i,
  input  logic       c_type_i,
  input  logic       branch_taken_i,
  output logic       alu_src_b_o,
  output logic       alu_src_a_o,
  output logic       dmem_req_o,
  output logic       dmem_we_o,
  input  logic       dmem_ready_i,
  output logic       rf_we_o,
  output logic [1:0] wb_sel_o,
  output logic       pc_we_o,
  output logic [1:0] pc_sel_o,
  output logic       halted_o,
  output logic       fault_o,
  output logic [2:0] state_o
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_WAIT = CW'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_FAULT  = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    C_R, C_LOAD, C_IALU, C_JR, C_STORE, C_BRANCH, C_U, C_J
  } iclass_t;

  state_t        state;
  iclass_t       iclass;
  iclass_t       decode_class;
  logic          decode_legal;
  logic [CW-1:0] wait_cnt;
  logic [1:0]    wb_sel_q;
  logic [1:0]    pc_sel_q;

  // The PC register lives in the datapath; this block only steers its mux to
  // RESET_PC, so here the value is only sanity-checked for width.
  if ($bits(RESET_PC) != 19) begin : g_reset_pc_width
    $error("RESET_PC must be 19 bits wide");
  end

  // Classify the instruction from the decoder flags; exactly one non-halt flag is legal.
  always_comb begin
    decode_class = C_R;
    decode_legal = $onehot({r_type_i, i_type_i, s_type_i, b_type_i, u_type_i, j_type_i});
    if (i_type_i) begin
      if (op_i == I_TYPE_0)      decode_class = C_LOAD;
      else if (op_i == I_TYPE_1) decode_class = C_IALU;
      else if (op_i == I_TYPE_2) decode_class = C_JR;
      else                       decode_legal = 1'b0;
    end else if (s_type_i) begin
      decode_class = C_STORE;
    end else if (b_type_i) begin
      decode_class = C_BRANCH;
    end else if (u_type_i) begin
      decode_class = C_U;
    end else if (j_type_i) begin
      decode_class = C_J;
    end
  end

  // Sequencer state, handshake timeout counter and the selects latched at EXEC exit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_RESET;
      iclass   <= C_R;
      wait_cnt <= '0;
      wb_sel_q <= 2'd0;
      pc_sel_q <= 2'd0;
    end else begin
      case (state)
        S_RESET: begin
          state <= S_FETCH;
        end
        S_FETCH: begin
          if (imem_ready_i) begin
            wait_cnt <= '0;
            state    <= S_DECODE;
          end else if (wait_cnt == LAST_WAIT) begin
            wait_cnt <= '0;
            state    <= S_FAULT;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        S_DECODE: begin
          if (c_type_i) begin
            state <= S_HALT;
          end else if (!decode_legal) begin
            state <= S_FAULT;
          end else begin
            iclass <= decode_class;
            state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (iclass)
            C_LOAD:      wb_sel_q <= 2'd1;
            C_JR, C_J:   wb_sel_q <= 2'd2;
            C_U:         wb_sel_q <= 2'd3;
            default:     wb_sel_q <= 2'd0;
          endcase
          case (iclass)
            C_JR:        pc_sel_q <= 2'd2;
            C_J:         pc_sel_q <= 2'd1;
            default:     pc_sel_q <= 2'd0;
          endcase
          case (iclass)
            C_BRANCH:        state <= S_FETCH;
            C_LOAD, C_STORE: state <= S_MEM;
            default:         state <= S_WB;
          endcase
        end
        S_MEM: begin
          if (dmem_ready_i) begin
            wait_cnt <= '0;
            state    <= (iclass == C_LOAD) ? S_WB : S_FETCH;
          end else if (wait_cnt == LAST_WAIT) begin
            wait_cnt <= '0;
            state    <= S_FAULT;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        S_WB: begin
          state <= S_FETCH;
        end
        default: begin
          state <= state;
        end
      endcase
    end
  end

  // Output decode from the registered state; enables are suppressed while rst is high.
  always_comb begin
    imem_req_o  = 1'b0;
    ir_we_o     = 1'b0;
    alu_src_a_o = 1'b0;
    alu_src_b_o = 1'b0;
    dmem_req_o  = 1'b0;
    dmem_we_o   = 1'b0;
    rf_we_o     = 1'b0;
    wb_sel_o    = 2'd0;
    pc_we_o     = 1'b0;
    pc_sel_o    = 2'd0;
    halted_o    = 1'b0;
    fault_o     = 1'b0;
    case (state)
      S_RESET: begin
        pc_we_o  = 1'b1;
        pc_sel_o = 2'd3;
      end
      S_FETCH: begin
        imem_req_o = 1'b1;
        ir_we_o    = imem_ready_i;
      end
      S_EXEC: begin
        alu_src_b_o = (iclass == C_LOAD) || (iclass == C_IALU) ||
                      (iclass == C_JR)   || (iclass == C_STORE);
        if (iclass == C_BRANCH) begin
          pc_we_o  = 1'b1;
          pc_sel_o = {1'b0, branch_taken_i};
        end
      end
      S_MEM: begin
        dmem_req_o = 1'b1;
        dmem_we_o  = (iclass == C_STORE);
        wb_sel_o   = wb_sel_q;
        pc_sel_o   = pc_sel_q;
        pc_we_o    = (iclass == C_STORE) && dmem_ready_i;
      end
      S_WB: begin
        rf_we_o  = 1'b1;
        pc_we_o  = 1'b1;
        wb_sel_o = wb_sel_q;
        pc_sel_o = pc_sel_q;
      end
      S_HALT:  halted_o = 1'b1;
      S_FAULT: fault_o  = 1'b1;
      default: begin
        halted_o = 1'b0;
      end
    endcase
    if (rst) begin
      imem_req_o = 1'b0;
      ir_we_o    = 1'b0;
      dmem_req_o = 1'b0;
      dmem_we_o  = 1'b0;
      rf_we_o    = 1'b0;
      pc_we_o    = 1'b0;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Self-checking bench for cpu_ctrl_fsm. A generator turns instruction-level
// descriptions (class, fetch/memory wait counts) into a per-cycle timeline of
// inputs and required outputs using the sequencer's latency rules; one process
// replays the timeline into the DUT and compares every cycle.
module tb_cpu_ctrl_fsm;

  localparam int         MEM_TIMEOUT = 16;
  localparam logic [3:0] I_TYPE_0    = 4'h0;
  localparam logic [3:0] I_TYPE_1    = 4'h1;
  localparam logic [3:0] I_TYPE_2    = 4'h2;

  localparam int K_R = 0, K_LOAD = 1, K_IALU = 2, K_JR = 3, K_STORE = 4;
  localparam int K_BRANCH = 5, K_U = 6, K_J = 7, K_HALT = 8, K_NONE = 9, K_MULTI = 10;

  // flags bit order: 6 r, 5 i, 4 s, 3 b, 2 u, 1 j, 0 c
  typedef struct packed {
    logic       rst;
    logic       imem_ready;
    logic       dmem_ready;
    logic       branch_taken;
    logic [6:0] flags;
    logic [3:0] op;
    logic       chk_full;
    logic [2:0] state;
    logic       imem_req;
    logic       ir_we;
    logic       dmem_req;
    logic       dmem_we;
    logic       rf_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic [1:0] wb_sel;
    logic       halted;
    logic       fault;
    logic       chk_alu;
    logic       alu_a;
    logic       alu_b;
  } cyc_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       imem_ready = 1'b0, dmem_ready = 1'b0, branch_taken = 1'b0;
  logic [6:0] flags = 7'd0;
  logic [3:0] op = 4'd0;
  logic       imem_req, ir_we, alu_src_b, alu_src_a, dmem_req, dmem_we;
  logic       rf_we, pc_we, halted, fault;
  logic [1:0] wb_sel, pc_sel;
  logic [2:0] state;

  cyc_t       q[$];
  logic [6:0] cur_flags = 7'd0;
  logic [3:0] cur_op = 4'd0;
  int         checks = 0;
  int         errors = 0;
  int         cycle = 0;

  cpu_ctrl_fsm #(
    .RESET_PC(19'h0), .MEM_TIMEOUT(MEM_TIMEOUT),
    .I_TYPE_0(I_TYPE_0), .I_TYPE_1(I_TYPE_1), .I_TYPE_2(I_TYPE_2)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_req_o(imem_req), .imem_ready_i(imem_ready), .ir_we_o(ir_we),
    .op_i(op),
    .r_type_i(flags[6]), .i_type_i(flags[5]), .s_type_i(flags[4]), .b_type_i(flags[3]),
    .u_type_i(flags[2]), .j_type_i(flags[1]), .c_type_i(flags[0]),
    .branch_taken_i(branch_taken),
    .alu_src_b_o(alu_src_b), .alu_src_a_o(alu_src_a),
    .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .dmem_ready_i(dmem_ready),
    .rf_we_o(rf_we), .wb_sel_o(wb_sel), .pc_we_o(pc_we), .pc_sel_o(pc_sel),
    .halted_o(halted), .fault_o(fault), .state_o(state)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, required %0h", name, cycle, act, exp);
    end
  endtask

  // A cycle with junk on the don't-care inputs and the current decoder word held.
  function automatic cyc_t blank();
    cyc_t c;
    c = '0;
    c.imem_ready   = 1'($urandom);
    c.dmem_ready   = 1'($urandom);
    c.branch_taken = 1'($urandom);
    c.flags        = cur_flags;
    c.op           = cur_op;
    c.chk_full     = 1'b1;
    return c;
  endfunction

  task automatic genReset(input int n);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c = blank();
      c.rst = 1'b1;
      c.chk_full = 1'b0;
      q.push_back(c);
    end
    c = blank();
    c.state = 3'd0;
    c.pc_we = 1'b1;
    c.pc_sel = 2'd3;
    q.push_back(c);
  endtask

  task automatic genTerminal(input logic [2:0] st, input int n);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c = blank();
      c.state  = st;
      c.halted = (st == 3'd6);
      c.fault  = (st == 3'd7);
      q.push_back(c);
    end
  endtask

  task automatic genFetch(input int w);
    cyc_t c;
    for (int i = 0; i < w && i < MEM_TIMEOUT; i++) begin
      c = blank();
      c.flags = 7'($urandom);
      c.op = 4'($urandom);
      c.imem_ready = 1'b0;
      c.state = 3'd1;
      c.imem_req = 1'b1;
      q.push_back(c);
    end
    if (w < MEM_TIMEOUT) begin
      c = blank();
      c.flags = 7'($urandom);
      c.op = 4'($urandom);
      c.imem_ready = 1'b1;
      c.state = 3'd1;
      c.imem_req = 1'b1;
      c.ir_we = 1'b1;
      q.push_back(c);
    end
  endtask

  task automatic genMem(input int w, input logic store, output logic timed_out);
    cyc_t c;
    timed_out = (w >= MEM_TIMEOUT);
    for (int i = 0; i < w && i < MEM_TIMEOUT; i++) begin
      c = blank();
      c.dmem_ready = 1'b0;
      c.state = 3'd4;
      c.dmem_req = 1'b1;
      c.dmem_we = store;
      q.push_back(c);
    end
    if (!timed_out) begin
      c = blank();
      c.dmem_ready = 1'b1;
      c.state = 3'd4;
      c.dmem_req = 1'b1;
      c.dmem_we = store;
      c.pc_we = store;
      c.pc_sel = 2'd0;
      q.push_back(c);
    end
  endtask

  function automatic logic [6:0] flagsFor(input int kind);
    int a, b;
    case (kind)
      K_R:                    return 7'b1000000;
      K_LOAD, K_IALU, K_JR:   return 7'b0100000;
      K_STORE:                return 7'b0010000;
      K_BRANCH:               return 7'b0001000;
      K_U:                    return 7'b0000100;
      K_J:                    return 7'b0000010;
      K_HALT:                 return 7'b0000001;
      K_MULTI: begin
        a = 1 + int'($urandom % 6);
        b = 1 + ((a - 1) + 1 + int'($urandom % 5)) % 6;
        return 7'((1 << a) | (1 << b));
      end
      default:                return 7'b0000000;
    endcase
  endfunction

  // One whole instruction, from its first fetch cycle to the cycle before the next fetch.
  task automatic genInstr(input int kind, input int fw, input int mw, input int taken, input int hold);
    cyc_t c;
    logic tk, to;
    genFetch(fw);
    if (fw >= MEM_TIMEOUT) begin
      genTerminal(3'd7, hold);
      genReset(1);
      return;
    end
    cur_flags = flagsFor(kind);
    cur_op = (kind == K_LOAD) ? I_TYPE_0 : (kind == K_IALU) ? I_TYPE_1 :
             (kind == K_JR) ? I_TYPE_2 : 4'($urandom);
    c = blank();
    c.state = 3'd2;
    q.push_back(c);
    if (kind >= K_HALT) begin
      genTerminal((kind == K_HALT) ? 3'd6 : 3'd7, hold);
      genReset(1);
      return;
    end
    c = blank();
    c.state = 3'd3;
    if (kind == K_R) begin
      c.chk_alu = 1'b1;
    end else if (kind == K_LOAD || kind == K_IALU || kind == K_JR || kind == K_STORE) begin
      c.chk_alu = 1'b1;
      c.alu_b = 1'b1;
    end else if (kind == K_BRANCH) begin
      tk = (taken < 0) ? 1'($urandom) : 1'(taken);
      c.branch_taken = tk;
      c.pc_we = 1'b1;
      c.pc_sel = {1'b0, tk};
    end
    q.push_back(c);
    if (kind == K_BRANCH) return;
    if (kind == K_LOAD || kind == K_STORE) begin
      genMem(mw, (kind == K_STORE), to);
      if (to) begin
        genTerminal(3'd7, hold);
        genReset(1);
        return;
      end
      if (kind == K_STORE) return;
    end
    c = blank();
    c.state = 3'd5;
    c.rf_we = 1'b1;
    c.pc_we = 1'b1;
    c.wb_sel = (kind == K_LOAD) ? 2'd1 : (kind == K_JR || kind == K_J) ? 2'd2 :
               (kind == K_U) ? 2'd3 : 2'd0;
    c.pc_sel = (kind == K_JR) ? 2'd2 : (kind == K_J) ? 2'd1 : 2'd0;
    q.push_back(c);
  endtask

  // Replay the timeline: drive just after each rising edge, compare on the falling edge.
  task automatic applyStimulus();
    cyc_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      @(posedge clk);
      #1;
      cycle++;
      rst          = c.rst;
      imem_ready   = c.imem_ready;
      dmem_ready   = c.dmem_ready;
      branch_taken = c.branch_taken;
      flags        = c.flags;
      op           = c.op;
      @(negedge clk);
      if (c.chk_full) begin
        checkOutput("state", 16'(state), 16'(c.state));
        checkOutput("imem_req", 16'(imem_req), 16'(c.imem_req));
        checkOutput("ir_we", 16'(ir_we), 16'(c.ir_we));
        checkOutput("dmem_req", 16'(dmem_req), 16'(c.dmem_req));
        checkOutput("rf_we", 16'(rf_we), 16'(c.rf_we));
        checkOutput("pc_we", 16'(pc_we), 16'(c.pc_we));
        checkOutput("halted", 16'(halted), 16'(c.halted));
        checkOutput("fault", 16'(fault), 16'(c.fault));
        if (c.dmem_req) checkOutput("dmem_we", 16'(dmem_we), 16'(c.dmem_we));
        if (c.pc_we) checkOutput("pc_sel", 16'(pc_sel), 16'(c.pc_sel));
        if (c.rf_we) checkOutput("wb_sel", 16'(wb_sel), 16'(c.wb_sel));
        if (c.chk_alu) begin
          checkOutput("alu_src_a", 16'(alu_src_a), 16'(c.alu_a));
          checkOutput("alu_src_b", 16'(alu_src_b), 16'(c.alu_b));
        end
      end else begin
        checkOutput("rst_enables", 16'({imem_req, ir_we, dmem_req, rf_we, pc_we}), 16'd0);
      end
    end
  endtask

  // Build the directed and random timeline, pin the model on a few literals, then run it.
  initial begin
    int s0, n, r, kind, fw, mw;
    cyc_t c;
    genReset(2);

    s0 = q.size();
    genInstr(K_R, 0, 0, -1, 0);
    checkOutput("model_r_len", 16'(q.size() - s0), 16'd4);
    checkOutput("model_r_wb", 16'({q[s0 + 3].rf_we, q[s0 + 3].pc_we, q[s0 + 3].pc_sel}), 16'b1100);

    s0 = q.size();
    genInstr(K_LOAD, 0, 3, -1, 0);
    n = 0;
    for (int i = s0; i < q.size(); i++) if (q[i].dmem_req && !q[i].dmem_we) n++;
    checkOutput("model_ld_len", 16'(q.size() - s0), 16'd8);
    checkOutput("model_ld_req", 16'(n), 16'd4);
    checkOutput("model_ld_wbsel", 16'(q[s0 + 7].wb_sel), 16'd1);

    s0 = q.size();
    genInstr(K_BRANCH, 0, 0, 1, 0);
    checkOutput("model_br_len", 16'(q.size() - s0), 16'd3);
    checkOutput("model_br_sel", 16'({q[s0 + 2].pc_we, q[s0 + 2].pc_sel, q[s0 + 2].rf_we}), 16'b1010);
    genInstr(K_BRANCH, 1, 0, 0, 0);
    genInstr(K_STORE, 2, 1, -1, 0);

    genInstr(K_HALT, 0, 0, -1, 20);
    genInstr(K_NONE, 0, 0, -1, 5);

    s0 = q.size();
    genInstr(K_R, 16, 0, -1, 4);
    checkOutput("model_tmo_req", 16'({q[s0 + 15].imem_req, q[s0 + 16].imem_req}), 16'b10);
    checkOutput("model_tmo_state", 16'(q[s0 + 16].state), 16'd7);

    // Load interrupted by reset while its data request is outstanding.
    genFetch(0);
    cur_flags = flagsFor(K_LOAD);
    cur_op = I_TYPE_0;
    c = blank(); c.state = 3'd2; q.push_back(c);
    c = blank(); c.state = 3'd3; c.chk_alu = 1'b1; c.alu_b = 1'b1; q.push_back(c);
    c = blank(); c.state = 3'd4; c.dmem_ready = 1'b0; c.dmem_req = 1'b1; q.push_back(c);
    genReset(1);
    genInstr(K_J, 0, 0, -1, 0);
    genInstr(K_STORE, 0, 16, -1, 3);

    for (int i = 0; i < 250; i++) begin
      r = int'($urandom % 100);
      if (r < 5)       kind = K_HALT;
      else if (r < 9)  kind = K_NONE;
      else if (r < 13) kind = K_MULTI;
      else             kind = int'($urandom % 8);
      r = int'($urandom % 100);
      fw = (r < 3) ? 16 : (r < 8) ? 15 : int'($urandom % 3);
      r = int'($urandom % 100);
      mw = (r < 4) ? 16 : (r < 9) ? 15 : int'($urandom % 4);
      genInstr(kind, fw, mw, -1, 3 + int'($urandom % 8));
    end

    applyStimulus();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
